// File: rtl/snake_row_render.sv
// Builds one grid row of snake occupancy (body mask + head) in a back buffer and commits it to a front buffer that answers per-column class queries.
// Optional border marking is enabled by defining SNAKE_ROW_RENDER_BORDER_EN.
module snake_row_render (
  input  logic         clock,
  input  logic         reset,
  input  logic [191:0] snake_x_temp,
  input  logic [191:0] snake_y_temp,
  input  logic [31:0]  snake_piece_is_display,
  input  logic         scan_start,
  input  logic [5:0]   scan_row,
  input  logic [5:0]   query_x,
  output logic [1:0]   pixel_class,
  output logic [5:0]   front_row,
  output logic         busy,
  output logic         row_ready,
  output logic         overrun
);

  localparam int unsigned COORD_W  = 6;
  localparam int unsigned NUM_SEG  = 32;
  localparam int unsigned PACK_W   = COORD_W * NUM_SEG;
  localparam int unsigned GRID_W   = 48;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned LAST_ROW = 26;
  localparam int unsigned LAST_COL = GRID_W - 1;

  localparam logic [1:0] CLS_EMPTY  = 2'b00;
  localparam logic [1:0] CLS_BODY   = 2'b01;
  localparam logic [1:0] CLS_HEAD   = 2'b10;
  localparam logic [1:0] CLS_BORDER = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [PACK_W-1:0]  snap_x_q, snap_x_d;
  logic [PACK_W-1:0]  snap_y_q, snap_y_d;
  logic [NUM_SEG-1:0] snap_disp_q, snap_disp_d;
  logic [COORD_W-1:0] snap_row_q, snap_row_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [GRID_W-1:0]  back_body_q, back_body_d;
  logic [COORD_W-1:0] back_head_col_q, back_head_col_d;
  logic               back_head_v_q, back_head_v_d;

  logic [GRID_W-1:0]  front_body_q, front_body_d;
  logic [COORD_W-1:0] front_head_col_q, front_head_col_d;
  logic               front_head_v_q, front_head_v_d;
  logic [COORD_W-1:0] front_row_q, front_row_d;

  logic [1:0]         pixel_class_q, pixel_class_d;
  logic               busy_q, busy_d;
  logic               row_ready_q, row_ready_d;
  logic               overrun_q, overrun_d;

  logic [COORD_W-1:0] seg_x_c;
  logic [COORD_W-1:0] seg_y_c;
  logic               seg_hit_c;
  logic               on_border_c;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (scan_start) state_d = S_SCAN;
      S_SCAN:   if (idx_q == IDX_W'(NUM_SEG - 1)) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The snapshot shifts right each SCAN cycle, so the current segment is always in the low bits
  assign seg_x_c   = snap_x_q[COORD_W-1:0];
  assign seg_y_c   = snap_y_q[COORD_W-1:0];
  assign seg_hit_c = snap_disp_q[0] && (seg_y_c == snap_row_q) && (seg_x_c < COORD_W'(GRID_W));

  // Scan datapath, buffers and status outputs
  always_comb begin
    snap_x_d         = snap_x_q;
    snap_y_d         = snap_y_q;
    snap_disp_d      = snap_disp_q;
    snap_row_d       = snap_row_q;
    idx_d            = idx_q;
    back_body_d      = back_body_q;
    back_head_col_d  = back_head_col_q;
    back_head_v_d    = back_head_v_q;
    front_body_d     = front_body_q;
    front_head_col_d = front_head_col_q;
    front_head_v_d   = front_head_v_q;
    front_row_d      = front_row_q;
    busy_d           = busy_q;
    row_ready_d      = 1'b0;
    overrun_d        = overrun_q | (scan_start && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          snap_x_d        = snake_x_temp;
          snap_y_d        = snake_y_temp;
          snap_disp_d     = snake_piece_is_display;
          snap_row_d      = scan_row;
          idx_d           = '0;
          back_body_d     = '0;
          back_head_col_d = '0;
          back_head_v_d   = 1'b0;
          busy_d          = 1'b1;
        end
      end
      S_SCAN: begin
        if (seg_hit_c) begin
          if (idx_q == '0) begin
            back_head_col_d = seg_x_c;
            back_head_v_d   = 1'b1;
          end else begin
            back_body_d = back_body_q | (GRID_W'(1) << seg_x_c);
          end
        end
        snap_x_d    = snap_x_q >> COORD_W;
        snap_y_d    = snap_y_q >> COORD_W;
        snap_disp_d = snap_disp_q >> 1;
        idx_d       = idx_q + IDX_W'(1);
      end
      S_COMMIT: begin
        front_body_d     = back_body_q;
        front_head_col_d = back_head_col_q;
        front_head_v_d   = back_head_v_q;
        front_row_d      = snap_row_q;
        row_ready_d      = 1'b1;
        busy_d           = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

`ifdef SNAKE_ROW_RENDER_BORDER_EN
  assign on_border_c = (query_x == '0) || (query_x == COORD_W'(LAST_COL)) ||
                       (front_row_q == '0) || (front_row_q == COORD_W'(LAST_ROW));
`else
  assign on_border_c = 1'b0;
`endif

  // Front-buffer lookup with priority border > head > body > empty
  always_comb begin
    pixel_class_d = CLS_EMPTY;
    if (query_x < COORD_W'(GRID_W)) begin
      if (on_border_c) begin
        pixel_class_d = CLS_BORDER;
      end else if (front_head_v_q && (front_head_col_q == query_x)) begin
        pixel_class_d = CLS_HEAD;
      end else if (front_body_q[query_x]) begin
        pixel_class_d = CLS_BODY;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_x_q         <= '0;
      snap_y_q         <= '0;
      snap_disp_q      <= '0;
      snap_row_q       <= '0;
      idx_q            <= '0;
      back_body_q      <= '0;
      back_head_col_q  <= '0;
      back_head_v_q    <= 1'b0;
      front_body_q     <= '0;
      front_head_col_q <= '0;
      front_head_v_q   <= 1'b0;
      front_row_q      <= '0;
      pixel_class_q    <= CLS_EMPTY;
      busy_q           <= 1'b0;
      row_ready_q      <= 1'b0;
      overrun_q        <= 1'b0;
    end else begin
      snap_x_q         <= snap_x_d;
      snap_y_q         <= snap_y_d;
      snap_disp_q      <= snap_disp_d;
      snap_row_q       <= snap_row_d;
      idx_q            <= idx_d;
      back_body_q      <= back_body_d;
      back_head_col_q  <= back_head_col_d;
      back_head_v_q    <= back_head_v_d;
      front_body_q     <= front_body_d;
      front_head_col_q <= front_head_col_d;
      front_head_v_q   <= front_head_v_d;
      front_row_q      <= front_row_d;
      pixel_class_q    <= pixel_class_d;
      busy_q           <= busy_d;
      row_ready_q      <= row_ready_d;
      overrun_q        <= overrun_d;
    end
  end

  assign pixel_class = pixel_class_q;
  assign front_row   = front_row_q;
  assign busy        = busy_q;
  assign row_ready   = row_ready_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_snake_row_render.sv
// Directed bench for snake_row_render: scan timing, occupancy classes, overrun, snapshot isolation, mid-scan reset, border option.
module tb_snake_row_render;

`ifdef SNAKE_ROW_RENDER_BORDER_EN
  localparam logic [1:0] B_EDGE = 2'b11;
`else
  localparam logic [1:0] B_EDGE = 2'b00;
`endif

  logic         clock;
  logic         reset;
  logic [191:0] snake_x_temp;
  logic [191:0] snake_y_temp;
  logic [31:0]  snake_piece_is_display;
  logic         scan_start;
  logic [5:0]   scan_row;
  logic [5:0]   query_x;
  logic [1:0]   pixel_class;
  logic [5:0]   front_row;
  logic         busy;
  logic         row_ready;
  logic         overrun;

  int n_assert;
  int n_fail;

  snake_row_render dut (
    .clock                  (clock),
    .reset                  (reset),
    .snake_x_temp           (snake_x_temp),
    .snake_y_temp           (snake_y_temp),
    .snake_piece_is_display (snake_piece_is_display),
    .scan_start             (scan_start),
    .scan_row               (scan_row),
    .query_x                (query_x),
    .pixel_class            (pixel_class),
    .front_row              (front_row),
    .busy                   (busy),
    .row_ready              (row_ready),
    .overrun                (overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic query(input logic [5:0] x, input logic [1:0] exp, input string tag);
    query_x = x;
    tick();
    chk(32'(pixel_class), 32'(exp), tag);
  endtask

  // Three-segment snake (14,20),(13,20),(12,20) plus a segment 3 at (52,20)
  task automatic load_snake();
    snake_x_temp = '0;
    snake_y_temp = '0;
    snake_x_temp[5:0]   = 6'd14; snake_y_temp[5:0]   = 6'd20;
    snake_x_temp[11:6]  = 6'd13; snake_y_temp[11:6]  = 6'd20;
    snake_x_temp[17:12] = 6'd12; snake_y_temp[17:12] = 6'd20;
    snake_x_temp[23:18] = 6'd52; snake_y_temp[23:18] = 6'd20;
  endtask

  // Cycle 0 is the cycle with scan_start high; loop variable c is the cycle being observed
  task automatic run_scan(input logic [5:0] row, input logic [31:0] disp, input int restart_cyc,
                          input int change_cyc, input int reset_cyc, input logic [1:0] hold_exp,
                          input string tag);
    int first;
    int pulses;
    logic exp_busy;
    first  = 0;
    pulses = 0;
    scan_row = row;
    snake_piece_is_display = disp;
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (row_ready) begin
        pulses++;
        if (first == 0) first = c;
      end
      exp_busy = (reset_cyc != 0) ? (c <= reset_cyc) : (c <= 33);
      chk(32'(busy), 32'(exp_busy), {tag, "_busy"});
      if (c == 16) chk(32'(pixel_class), 32'(hold_exp), {tag, "_hold"});
      query_x    = 6'd14;
      scan_start = (c == restart_cyc);
      if (c == restart_cyc) scan_row = 6'd19;
      if (c == change_cyc) begin
        snake_x_temp = '0;
        snake_y_temp = '0;
        snake_piece_is_display = '0;
        scan_row = 6'd19;
      end
      reset = (c == reset_cyc);
      tick();
    end
    reset = 1'b0;
    if (reset_cyc == 0) begin
      chk(32'(pulses), 32'd1, {tag, "_pulses"});
      chk(32'(first), 32'd34, {tag, "_ready_cycle"});
    end else begin
      chk(32'(pulses), 32'd0, {tag, "_pulses"});
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clock = 1'b0;
    reset = 1'b1;
    scan_start = 1'b0;
    scan_row = '0;
    query_x = '0;
    snake_piece_is_display = '0;
    load_snake();
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk(32'(busy), 32'd0, "rst_busy");
    chk(32'(row_ready), 32'd0, "rst_ready");
    chk(32'(overrun), 32'd0, "rst_overrun");
    chk(32'(front_row), 32'd0, "rst_front_row");
    query(6'd14, B_EDGE, "rst_q14");

    // Basic three-segment row
    run_scan(6'd20, 32'h7, 0, 0, 0, B_EDGE, "s20");
    chk(32'(front_row), 32'd20, "s20_front_row");
    query(6'd14, 2'b10, "s20_q14");
    query(6'd13, 2'b01, "s20_q13");
    query(6'd12, 2'b01, "s20_q12");
    query(6'd15, 2'b00, "s20_q15");
    query(6'd50, 2'b00, "s20_q50");

    // Tail hidden
    run_scan(6'd20, 32'h3, 0, 0, 0, 2'b10, "d3");
    query(6'd12, 2'b00, "d3_q12");
    query(6'd13, 2'b01, "d3_q13");
    query(6'd14, 2'b10, "d3_q14");

    // Row with no snake
    run_scan(6'd19, 32'h7, 0, 0, 0, 2'b10, "r19");
    chk(32'(front_row), 32'd19, "r19_front_row");
    query(6'd0,  B_EDGE, "r19_q0");
    query(6'd12, 2'b00, "r19_q12");
    query(6'd13, 2'b00, "r19_q13");
    query(6'd14, 2'b00, "r19_q14");
    query(6'd47, B_EDGE, "r19_q47");
    query(6'd63, 2'b00, "r19_q63");

    // Second scan_start in cycle 5
    chk(32'(overrun), 32'd0, "ovr_before");
    run_scan(6'd20, 32'h7, 5, 0, 0, 2'b00, "ovr");
    chk(32'(overrun), 32'd1, "ovr_after");
    chk(32'(front_row), 32'd20, "ovr_front_row");
    query(6'd13, 2'b01, "ovr_q13");
    query(6'd14, 2'b10, "ovr_q14");

    // Inputs changed in cycle 3; segment 3 at x=52 must be ignored
    load_snake();
    run_scan(6'd20, 32'hF, 0, 3, 0, 2'b10, "snap");
    chk(32'(front_row), 32'd20, "snap_front_row");
    query(6'd14, 2'b10, "snap_q14");
    query(6'd12, 2'b01, "snap_q12");
    query(6'd4,  2'b00, "snap_q4");
    chk(32'(overrun), 32'd1, "snap_overrun_sticky");

    // Reset in cycle 10 of a scan
    load_snake();
    run_scan(6'd20, 32'h7, 0, 0, 10, B_EDGE, "mrst");
    chk(32'(busy), 32'd0, "mrst_busy");
    chk(32'(overrun), 32'd0, "mrst_overrun");
    chk(32'(front_row), 32'd0, "mrst_front_row");
    query(6'd14, B_EDGE, "mrst_q14");
    query(6'd13, B_EDGE, "mrst_q13");
    query(6'd60, 2'b00, "mrst_q60");

    // Border option on an interior row
    run_scan(6'd5, 32'h7, 0, 0, 0, B_EDGE, "r5");
    chk(32'(front_row), 32'd5, "r5_front_row");
    query(6'd0, B_EDGE, "r5_q0");
    query(6'd1, 2'b00, "r5_q1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
